// File: rtl/classical_room_fuse_sequencer.sv
// OTP/antifuse program sequencer: waits for macro ready, drives a timed program pulse,
// settles, sense-verifies, retries a bounded number of times and latches blown/fail status.
`timescale 1ns/1ps
module classical_room_fuse_sequencer #(
  parameter int PROG_CYCLES   = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int MAX_RETRY     = 3,
  parameter int READY_TIMEOUT = 256
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           fuse_blow,
  input  logic                           otp_ready,
  input  logic                           otp_sense,
  output logic                           otp_prog,
  output logic                           otp_sense_en,
  output logic                           busy,
  output logic                           blown,
  output logic                           fail,
  output logic [$clog2(MAX_RETRY+2)-1:0] attempts
);

  localparam int AW        = $clog2(MAX_RETRY + 2);
  localparam int PHASE_MAX = (PROG_CYCLES > SETTLE_CYCLES) ? PROG_CYCLES : SETTLE_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int TW        = $clog2(READY_TIMEOUT + 1);

  localparam logic [PW-1:0] PROG_LAST    = PW'(PROG_CYCLES - 1);
  localparam logic [PW-1:0] SETTLE_LAST  = PW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(READY_TIMEOUT - 1);
  localparam logic [AW-1:0] ATT_LIMIT    = AW'(MAX_RETRY + 1);
  localparam logic [AW-1:0] ATT_SAT      = {AW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_PROG     = 3'd2,
    ST_SETTLE   = 3'd3,
    ST_SENSE    = 3'd4,
    ST_DONE     = 3'd5,
    ST_FAIL     = 3'd6
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [PW-1:0] phase_r, phase_nxt_s;
  logic [TW-1:0] timeout_r, timeout_nxt_s;
  logic [AW-1:0] attempts_r, attempts_nxt_s, attempts_inc_s;
  logic          prog_r, sense_en_r, busy_r, blown_r, fail_r;
  logic          prog_nxt_s, sense_en_nxt_s, busy_nxt_s, blown_nxt_s, fail_nxt_s;

  // State and sequencing counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      phase_r    <= {PW{1'b0}};
      timeout_r  <= {TW{1'b0}};
      attempts_r <= {AW{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      phase_r    <= phase_nxt_s;
      timeout_r  <= timeout_nxt_s;
      attempts_r <= attempts_nxt_s;
    end
  end

  // Next-state and counter update logic
  always_comb begin
    state_nxt_s    = state_r;
    phase_nxt_s    = phase_r;
    timeout_nxt_s  = timeout_r;
    attempts_nxt_s = attempts_r;
    attempts_inc_s = (attempts_r == ATT_SAT) ? attempts_r : attempts_r + AW'(1);
    case (state_r)
      ST_IDLE: begin
        if (fuse_blow) begin
          state_nxt_s   = ST_WAIT_RDY;
          timeout_nxt_s = {TW{1'b0}};
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_WAIT_RDY: begin
        if (otp_ready) begin
          state_nxt_s = ST_PROG;
          phase_nxt_s = {PW{1'b0}};
        end else if (timeout_r == TIMEOUT_LAST) begin
          state_nxt_s = ST_FAIL;
        end else begin
          timeout_nxt_s = timeout_r + TW'(1);
        end
      end
      ST_PROG: begin
        if (phase_r == PROG_LAST) begin
          state_nxt_s = ST_SETTLE;
          phase_nxt_s = {PW{1'b0}};
        end else begin
          phase_nxt_s = phase_r + PW'(1);
        end
      end
      ST_SETTLE: begin
        if (phase_r == SETTLE_LAST) begin
          state_nxt_s = ST_SENSE;
          phase_nxt_s = {PW{1'b0}};
        end else begin
          phase_nxt_s = phase_r + PW'(1);
        end
      end
      ST_SENSE: begin
        // The attempt is counted at the same edge that samples the sense result
        attempts_nxt_s = attempts_inc_s;
        if (otp_sense) begin
          state_nxt_s = ST_DONE;
        end else if (attempts_inc_s >= ATT_LIMIT) begin
          state_nxt_s = ST_FAIL;
        end else begin
          state_nxt_s   = ST_WAIT_RDY;
          timeout_nxt_s = {TW{1'b0}};
        end
      end
      ST_DONE: state_nxt_s = ST_DONE;
      ST_FAIL: state_nxt_s = ST_FAIL;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so registered outputs track the state register
  always_comb begin
    prog_nxt_s     = 1'b0;
    sense_en_nxt_s = 1'b0;
    busy_nxt_s     = 1'b0;
    blown_nxt_s    = 1'b0;
    fail_nxt_s     = 1'b0;
    case (state_nxt_s)
      ST_IDLE:     busy_nxt_s = 1'b0;
      ST_WAIT_RDY: busy_nxt_s = 1'b1;
      ST_PROG: begin
        busy_nxt_s = 1'b1;
        prog_nxt_s = 1'b1;
      end
      ST_SETTLE:   busy_nxt_s = 1'b1;
      ST_SENSE: begin
        busy_nxt_s     = 1'b1;
        sense_en_nxt_s = 1'b1;
      end
      ST_DONE:     blown_nxt_s = 1'b1;
      ST_FAIL:     fail_nxt_s  = 1'b1;
      default:     busy_nxt_s  = 1'b0;
    endcase
  end

  // Output registers; reset drops the program strobe immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prog_r     <= 1'b0;
      sense_en_r <= 1'b0;
      busy_r     <= 1'b0;
      blown_r    <= 1'b0;
      fail_r     <= 1'b0;
    end else begin
      prog_r     <= prog_nxt_s;
      sense_en_r <= sense_en_nxt_s;
      busy_r     <= busy_nxt_s;
      blown_r    <= blown_nxt_s;
      fail_r     <= fail_nxt_s;
    end
  end

  assign otp_prog     = prog_r;
  assign otp_sense_en = sense_en_r;
  assign busy         = busy_r;
  assign blown        = blown_r;
  assign fail         = fail_r;
  assign attempts     = attempts_r;

endmodule

// File: tb/tb_classical_room_fuse_sequencer.sv
// Directed bench for the fuse sequencer: a timeline model predicts every output on every
// cycle after a fuse_blow, and literal expectations pin the model's key timing points.
`timescale 1ns/1ps
module tb_classical_room_fuse_sequencer;

  localparam int PROG   = 16;
  localparam int SETTLE = 4;
  localparam int RETRY  = 3;
  localparam int TMO    = 256;

  logic       clk = 1'b0;
  logic       reset_n, fuse_blow, otp_ready, otp_sense;
  logic       otp_prog, otp_sense_en, busy, blown, fail;
  logic [2:0] attempts;

  classical_room_fuse_sequencer #(
    .PROG_CYCLES(PROG), .SETTLE_CYCLES(SETTLE), .MAX_RETRY(RETRY), .READY_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fuse_blow(fuse_blow), .otp_ready(otp_ready),
    .otp_sense(otp_sense), .otp_prog(otp_prog), .otp_sense_en(otp_sense_en),
    .busy(busy), .blown(blown), .fail(fail), .attempts(attempts)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Plan of the current sequence: start cycle, ready-low cycles per attempt,
  // attempt number whose sense passes (0 = never), attempt whose wait times out (-1 = none)
  bit pl_active;
  int pl_start;
  int pl_wait [4];
  int pl_pass_at;
  int pl_timeout_at;

  int prog_count, overlap_count, first_prog_t, first_sense_t, first_blown_t, first_fail_t;

  function automatic logic [7:0] vec(bit p, bit s, bit b, bit bl, bit f, int a);
    logic [2:0] a3;
    a3 = a[2:0];
    return {p, s, b, bl, f, a3};
  endfunction

  // Expected outputs t cycles after the accepting fuse_blow edge, walked as a timeline of phases
  function automatic logic [7:0] model(int t);
    int pos;
    int att;
    pos = 1;
    att = 0;
    for (int k = 0; k < RETRY + 1; k++) begin
      if (k == pl_timeout_at) begin
        if (t < pos + TMO) return vec(0, 0, 1, 0, 0, att);
        return vec(0, 0, 0, 0, 1, att);
      end
      if (t < pos + pl_wait[k] + 1) return vec(0, 0, 1, 0, 0, att);
      pos += pl_wait[k] + 1;
      if (t < pos + PROG) return vec(1, 0, 1, 0, 0, att);
      pos += PROG;
      if (t < pos + SETTLE) return vec(0, 0, 1, 0, 0, att);
      pos += SETTLE;
      if (t < pos + 1) return vec(0, 1, 1, 0, 0, att);
      pos += 1;
      att++;
      if (att == pl_pass_at) return vec(0, 0, 0, 1, 0, att);
    end
    return vec(0, 0, 0, 0, 1, att);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: compare on the falling edge, return just after the next rising edge
  task automatic step();
    logic [7:0] exp_v, act_v;
    int t;
    @(negedge clk);
    act_v = {otp_prog, otp_sense_en, busy, blown, fail, attempts};
    if (pl_active) begin
      t = cyc - pl_start;
      exp_v = model(t);
      if (otp_prog) prog_count++;
      if (otp_prog && otp_sense_en) overlap_count++;
      if (otp_prog && first_prog_t < 0) first_prog_t = t;
      if (otp_sense_en && first_sense_t < 0) first_sense_t = t;
      if (blown && first_blown_t < 0) first_blown_t = t;
      if (fail && first_fail_t < 0) first_fail_t = t;
    end else begin
      t = -1;
      exp_v = 8'h00;
    end
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL trace cyc=%0d t=%0d: got prog/sen/busy/blown/fail/att=%b expected %b",
               cyc, t, act_v, exp_v);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic fire(input bit plan);
    fuse_blow = 1'b1;
    step();
    fuse_blow = 1'b0;
    if (plan) begin
      pl_start      = cyc - 1;
      pl_active     = 1'b1;
      prog_count    = 0;
      overlap_count = 0;
      first_prog_t  = -1;
      first_sense_t = -1;
      first_blown_t = -1;
      first_fail_t  = -1;
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    pl_active     = 1'b0;
    fuse_blow     = 1'b0;
    otp_ready     = 1'b1;
    otp_sense     = 1'b1;
    pl_wait       = '{0, 0, 0, 0};
    pl_pass_at    = 1;
    pl_timeout_at = -1;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    fuse_blow = 1'b0;
    otp_ready = 1'b1;
    otp_sense = 1'b1;
    pl_active = 1'b0;

    // Reset state
    do_reset();
    check("reset_attempts", int'(attempts), 0);
    check("reset_busy", int'(busy), 0);

    // Happy path
    fire(1'b1);
    repeat (30) step();
    check("s1_prog_width", prog_count, 16);
    check("s1_first_prog_t", first_prog_t, 2);
    check("s1_sense_t", first_sense_t, 22);
    check("s1_blown_t", first_blown_t, 23);
    check("s1_blown", int'(blown), 1);
    check("s1_attempts", int'(attempts), 1);
    check("s1_fail", int'(fail), 0);
    check("s1_overlap", overlap_count, 0);

    // Two failed verifies then pass
    do_reset();
    otp_sense  = 1'b0;
    pl_pass_at = 3;
    fire(1'b1);
    repeat (49) step();
    otp_sense = 1'b1;
    repeat (30) step();
    check("s2_prog_total", prog_count, 48);
    check("s2_blown_t", first_blown_t, 67);
    check("s2_attempts", int'(attempts), 3);
    check("s2_blown", int'(blown), 1);

    // Retries exhausted, then a spurious pulse in FAIL
    do_reset();
    otp_sense  = 1'b0;
    pl_pass_at = 0;
    fire(1'b1);
    repeat (95) step();
    check("s3_prog_total", prog_count, 64);
    check("s3_fail_t", first_fail_t, 89);
    check("s3_fail", int'(fail), 1);
    check("s3_blown", int'(blown), 0);
    check("s3_busy", int'(busy), 0);
    check("s3_attempts", int'(attempts), 4);
    fire(1'b0);
    repeat (5) step();
    check("s3_attempts_after_pulse", int'(attempts), 4);
    check("s3_prog_after_pulse", prog_count, 64);

    // Ready never rises
    do_reset();
    otp_ready     = 1'b0;
    pl_timeout_at = 0;
    fire(1'b1);
    repeat (262) step();
    check("s4_prog_total", prog_count, 0);
    check("s4_fail_t", first_fail_t, 257);
    check("s4_fail", int'(fail), 1);
    check("s4_attempts", int'(attempts), 0);

    // Ready rises on the last allowed wait cycle
    do_reset();
    otp_ready  = 1'b0;
    pl_wait[0] = 255;
    fire(1'b1);
    repeat (255) step();
    otp_ready = 1'b1;
    repeat (30) step();
    check("s4b_first_prog_t", first_prog_t, 257);
    check("s4b_fail_seen", first_fail_t, -1);
    check("s4b_blown", int'(blown), 1);

    // Spurious pulses during PROG and in DONE
    do_reset();
    fire(1'b1);
    repeat (3) step();
    fire(1'b0);
    repeat (30) step();
    fire(1'b0);
    repeat (5) step();
    check("s5_prog_width", prog_count, 16);
    check("s5_attempts", int'(attempts), 1);
    check("s5_blown", int'(blown), 1);
    check("s5_busy", int'(busy), 0);

    // Reset in the middle of the program pulse
    do_reset();
    fire(1'b1);
    repeat (7) step();
    #2;
    check("s6_prog_before_reset", int'(otp_prog), 1);
    reset_n   = 1'b0;
    pl_active = 1'b0;
    #1;
    check("s6_prog_async_drop", int'(otp_prog), 0);
    check("s6_busy_async_drop", int'(busy), 0);
    check("s6_outputs_zero", int'({otp_sense_en, blown, fail, attempts}), 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    fire(1'b1);
    repeat (30) step();
    check("s6_prog_width", prog_count, 16);
    check("s6_first_prog_t", first_prog_t, 2);
    check("s6_attempts", int'(attempts), 1);
    check("s6_blown", int'(blown), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
